// File: rtl/mix_tree_sequencer_if.sv
// Host-command and valve-driver bundle for one mixing-tree sequencer.
// The master side issues commands and observes valves; the slave side is the sequencer.
interface mix_tree_sequencer_if #(
  parameter int LEVELS = 3,
  parameter int CNT_W  = 16,
  parameter int RUN_W  = 8
);
  localparam int LVL_W = $clog2(LEVELS + 1);

  logic                 start;
  logic                 abort;
  logic [CNT_W-1:0]     fill_time;
  logic [CNT_W-1:0]     mix_time;
  logic [CNT_W-1:0]     xfer_time;
  logic [CNT_W-1:0]     flush_time;
  logic [2**LEVELS-1:0] inlet_valve;
  logic [LEVELS-1:0]    mix_pump;
  logic [LEVELS-1:0]    stage_valve;
  logic                 out_valve;
  logic                 busy;
  logic                 done;
  logic                 aborted;
  logic [LVL_W-1:0]     level;
  logic [RUN_W-1:0]     run_count;

  modport master (
    output start, abort, fill_time, mix_time, xfer_time, flush_time,
    input  inlet_valve, mix_pump, stage_valve, out_valve, busy, done, aborted, level, run_count
  );

  modport slave (
    input  start, abort, fill_time, mix_time, xfer_time, flush_time,
    output inlet_valve, mix_pump, stage_valve, out_valve, busy, done, aborted, level, run_count
  );
endinterface

// File: rtl/mix_tree_sequencer.sv
// Timed fill -> mix/transfer per level -> flush controller for a binary mixing tree.
// Every output is a flop loaded from the next-state decode, so no input reaches an output combinationally.
module mix_tree_sequencer #(
  parameter int LEVELS = 3,
  parameter int CNT_W  = 16,
  parameter int RUN_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  mix_tree_sequencer_if.slave bus
);
  localparam int LVL_W = $clog2(LEVELS + 1);
  localparam int INL_W = 2 ** LEVELS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_MIX,
    S_XFER,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] mix_q, mix_d;
  logic [CNT_W-1:0] xfer_q, xfer_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [RUN_W-1:0] run_count_q, run_count_d;
  logic             aborted_q, aborted_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             out_valve_q, out_valve_d;
  logic [INL_W-1:0] inlet_valve_q, inlet_valve_d;
  logic [LEVELS-1:0] mix_pump_q, mix_pump_d;
  logic [LEVELS-1:0] stage_valve_q, stage_valve_d;

  function automatic logic [CNT_W-1:0] clamp1(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_d      = fill_q;
    mix_d       = mix_q;
    xfer_d      = xfer_q;
    flush_d     = flush_q;
    level_d     = level_q;
    run_count_d = run_count_q;
    aborted_d   = aborted_q;

    // cnt holds the remaining cycles of the current phase minus one
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          fill_d    = clamp1(bus.fill_time);
          mix_d     = clamp1(bus.mix_time);
          xfer_d    = clamp1(bus.xfer_time);
          flush_d   = clamp1(bus.flush_time);
          cnt_d     = clamp1(bus.fill_time) - CNT_W'(1);
          aborted_d = 1'b0;
          level_d   = '0;
          state_d   = S_FILL;
        end
      end
      S_FILL, S_MIX, S_XFER: begin
        if (bus.abort) begin
          state_d   = S_FLUSH;
          cnt_d     = flush_q - CNT_W'(1);
          aborted_d = 1'b1;
          level_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (state_q == S_FILL) begin
          state_d = S_MIX;
          cnt_d   = mix_q - CNT_W'(1);
        end else if (state_q == S_MIX) begin
          state_d = S_XFER;
          cnt_d   = xfer_q - CNT_W'(1);
        end else if (level_q == LVL_W'(LEVELS - 1)) begin
          state_d = S_FLUSH;
          cnt_d   = flush_q - CNT_W'(1);
          level_d = '0;
        end else begin
          state_d = S_MIX;
          cnt_d   = mix_q - CNT_W'(1);
          level_d = level_q + LVL_W'(1);
        end
      end
      S_FLUSH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_DONE;
          if (!aborted_q) begin
            run_count_d = run_count_q + RUN_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    inlet_valve_d = (state_d == S_FILL) ? '1 : '0;
    mix_pump_d    = (state_d == S_MIX)  ? (LEVELS'(1) << level_d) : '0;
    stage_valve_d = (state_d == S_XFER) ? (LEVELS'(1) << level_d) : '0;
    out_valve_d   = (state_d == S_FLUSH);
    busy_d        = (state_d == S_FILL) || (state_d == S_MIX) ||
                    (state_d == S_XFER) || (state_d == S_FLUSH);
    done_d        = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      fill_q        <= '0;
      mix_q         <= '0;
      xfer_q        <= '0;
      flush_q       <= '0;
      level_q       <= '0;
      run_count_q   <= '0;
      aborted_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      out_valve_q   <= 1'b0;
      inlet_valve_q <= '0;
      mix_pump_q    <= '0;
      stage_valve_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fill_q        <= fill_d;
      mix_q         <= mix_d;
      xfer_q        <= xfer_d;
      flush_q       <= flush_d;
      level_q       <= level_d;
      run_count_q   <= run_count_d;
      aborted_q     <= aborted_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      out_valve_q   <= out_valve_d;
      inlet_valve_q <= inlet_valve_d;
      mix_pump_q    <= mix_pump_d;
      stage_valve_q <= stage_valve_d;
    end
  end

  assign bus.inlet_valve = inlet_valve_q;
  assign bus.mix_pump    = mix_pump_q;
  assign bus.stage_valve = stage_valve_q;
  assign bus.out_valve   = out_valve_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.aborted     = aborted_q;
  assign bus.level       = level_q;
  assign bus.run_count   = run_count_q;
endmodule

// File: tb/tb_mix_tree_sequencer.sv
// Randomized scoreboard bench for mix_tree_sequencer: each run's full expected
// per-cycle timeline is queued at start and checked by an independent monitor.
module tb_mix_tree_sequencer;
  localparam int LEVELS = 3;
  localparam int CNT_W  = 16;
  localparam int RUN_W  = 2;
  localparam int RC_MOD = 1 << RUN_W;

  logic clk = 1'b0;
  logic rst;
  bit   mon_en = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   model_rc = 0;
  bit   model_aborted = 1'b0;

  typedef struct {
    int         cyc;
    logic [7:0] inlet;
    logic [2:0] pump;
    logic [2:0] stage;
    logic       outv;
    logic       done;
    logic       aborted;
    logic [1:0] level;
    bit         rc_chk;
    int         rc;
  } exp_t;

  exp_t exp_q[$];

  mix_tree_sequencer_if #(.LEVELS(LEVELS), .CNT_W(CNT_W), .RUN_W(RUN_W)) bus ();

  mix_tree_sequencer #(.LEVELS(LEVELS), .CNT_W(CNT_W), .RUN_W(RUN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ph: 0 fill, 1 mix, 2 xfer, 3 flush, 4 done
  function automatic exp_t mk(input int c, input int ph, input int lvl, input logic ab,
                              input int rc, input bit chk);
    exp_t r;
    r.cyc     = c;
    r.inlet   = (ph == 0) ? 8'hFF : 8'h00;
    r.pump    = (ph == 1) ? 3'(1 << lvl) : 3'b000;
    r.stage   = (ph == 2) ? 3'(1 << lvl) : 3'b000;
    r.outv    = (ph == 3);
    r.done    = (ph == 4);
    r.aborted = ab;
    r.level   = (ph == 1 || ph == 2) ? 2'(lvl) : 2'd0;
    r.rc_chk  = chk;
    r.rc      = rc;
    return r;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    int   groups;
    bit   excl;
    if (mon_en) begin
      groups = int'(bus.inlet_valve != 0) + int'(bus.mix_pump != 0) +
               int'(bus.stage_valve != 0) + int'(bus.out_valve);
      excl = (groups <= 1) && ($countones(bus.mix_pump) <= 1) && ($countones(bus.stage_valve) <= 1);
      check("one_group_active", {31'b0, excl}, 32'd1);
      if (bus.busy === 1'b1 || bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_active: busy=%0b done=%0b with no run expected (cycle %0d)",
                   bus.busy, bus.done, cyc);
        end else begin
          e = exp_q.pop_front();
          check("active_cycle", cyc, e.cyc);
          check("outputs",
                {12'b0, bus.inlet_valve, bus.mix_pump, bus.stage_valve, bus.out_valve,
                 bus.busy, bus.done, bus.aborted, bus.level},
                {12'b0, e.inlet, e.pump, e.stage, e.outv, ~e.done, e.done, e.aborted, e.level});
          if (e.rc_chk) check("run_count_during_run", {30'b0, bus.run_count}, e.rc);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL missing_active: DUT idle, expected active for cycle %0d (cycle %0d)",
                 exp_q[0].cyc, cyc);
        e = exp_q.pop_front();
      end
    end
  end

  // Issues one run; ab_rel: -1 none, 0 random, >0 abort sampled at k+ab_rel.
  // rst_rel > 0 asserts reset at k+rst_rel instead of finishing the run.
  task automatic applyStimulus(input int f, input int m, input int x, input int u,
                               input int ab_rel, input bit noise, input int rst_rel);
    int fc, mc, xc, uc, p, k, j, end_pre, d, rc0, ph, lvl, r;
    bit ab;
    fc = (f == 0) ? 1 : f;
    mc = (m == 0) ? 1 : m;
    xc = (x == 0) ? 1 : x;
    uc = (u == 0) ? 1 : u;
    p  = fc + LEVELS * (mc + xc);
    if (ab_rel == 0) ab_rel = $urandom_range(1, p);
    ab      = (ab_rel > 0);
    k       = cyc;
    j       = ab ? k + ab_rel : -1;
    end_pre = ab ? j : k + p;
    d       = end_pre + uc + 1;
    rc0     = model_rc;

    bus.start      = 1'b1;
    bus.abort      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.fill_time  = CNT_W'(f);
    bus.mix_time   = CNT_W'(m);
    bus.xfer_time  = CNT_W'(x);
    bus.flush_time = CNT_W'(u);

    for (int n = 1; k + n <= end_pre; n++) begin
      if (n <= fc) begin
        ph  = 0;
        lvl = 0;
      end else begin
        r   = n - fc - 1;
        lvl = r / (mc + xc);
        ph  = ((r % (mc + xc)) < mc) ? 1 : 2;
      end
      exp_q.push_back(mk(k + n, ph, lvl, 1'b0, rc0, 1'b1));
    end
    for (int n = 1; n <= uc; n++) exp_q.push_back(mk(end_pre + n, 3, 0, ab, rc0, 1'b1));
    exp_q.push_back(mk(d, 4, 0, ab, rc0, 1'b0));
    model_aborted = ab;
    if (!ab) model_rc = (model_rc + 1) % RC_MOD;

    for (int c = k + 1; c <= d; c++) begin
      @(negedge clk);
      #1;
      if (rst_rel > 0 && c == k + rst_rel) begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        exp_q.delete();
        model_rc      = 0;
        model_aborted = 1'b0;
        break;
      end
      bus.start      = noise ? ($urandom_range(0, 2) == 0) : 1'b0;
      bus.abort      = (c == j) || (noise && c > end_pre && $urandom_range(0, 1) == 1);
      bus.fill_time  = CNT_W'($urandom_range(0, 9));
      bus.mix_time   = CNT_W'($urandom_range(0, 9));
      bus.xfer_time  = CNT_W'($urandom_range(0, 9));
      bus.flush_time = CNT_W'($urandom_range(0, 9));
    end
  endtask

  task automatic idleStep(input bit abort_pulse);
    @(negedge clk);
    #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.abort = abort_pulse;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_valves"}, {17'b0, bus.inlet_valve, bus.mix_pump, bus.stage_valve, bus.out_valve}, 32'd0);
    check({tag, "_busy_done_level"}, {28'b0, bus.busy, bus.done, bus.level}, 32'd0);
    check({tag, "_aborted"}, {31'b0, bus.aborted}, {31'b0, model_aborted});
    check({tag, "_run_count"}, {30'b0, bus.run_count}, model_rc);
  endtask

  initial begin : watchdog
    repeat (20000) @(posedge clk);
    $display("[TB] FAIL watchdog: cycle budget exhausted (cycle %0d)", cyc);
    $fatal(1, "[TB] bench stopped by watchdog");
  end

  initial begin : stimulus
    int gap;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.fill_time  = '0;
    bus.mix_time   = '0;
    bus.xfer_time  = '0;
    bus.flush_time = '0;
    @(negedge clk);
    #1;
    @(negedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    checkOutput("reset");

    idleStep(1'b1);
    idleStep(1'b0);
    checkOutput("abort_in_idle");

    applyStimulus(4, 5, 2, 3, -1, 1'b0, -1);
    idleStep(1'b0);
    checkOutput("plan_run");

    applyStimulus(0, 0, 0, 0, -1, 1'b0, -1);
    idleStep(1'b0);
    checkOutput("zero_durations");

    applyStimulus(4, 5, 2, 3, 14, 1'b0, -1);
    idleStep(1'b0);
    checkOutput("abort_mix1");

    applyStimulus(4, 5, 2, 3, -1, 1'b1, -1);
    idleStep(1'b0);
    checkOutput("ignored_start_abort");

    applyStimulus(3, 2, 4, 2, -1, 1'b0, 6);
    idleStep(1'b0);
    checkOutput("reset_in_xfer0");

    applyStimulus(1, 1, 1, 1, -1, 1'b0, -1);
    idleStep(1'b0);
    checkOutput("after_reset_run");

    for (int i = 0; i < 30; i++) begin
      applyStimulus($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
                    $urandom_range(0, 5), ($urandom_range(0, 2) == 0) ? 0 : -1,
                    1'($urandom_range(0, 1)), -1);
      idleStep(1'($urandom_range(0, 1)));
      checkOutput("random_run");
      gap = $urandom_range(0, 2);
      repeat (gap) idleStep(1'($urandom_range(0, 1)));
    end

    repeat (3) idleStep(1'b0);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mix_tree_sequencer.md
# mix_tree_sequencer

Parametrised controller that runs one complete fill–mix–transfer–flush cycle on a binary chamber/mixer tree of configurable depth. It generalises our fixed, hand-wired mixing trees into a timed, restartable sequence with abort and run accounting. It sits between the host command interface and the pneumatic valve/pump drivers of a single mixing tree.

## Interface
- LEVELS, default 3: mixer tree depth; leaf inlets = 2**LEVELS.
- CNT_W, default 16: width of phase-duration inputs and phase counter.
- RUN_W, default 8: width of completed-run counter.

- clk  input  1  rising-edge clock.
- rst  input  1  reset; one clock, synchronous, active-high.
- start  input  1  begin a run; sampled only in IDLE.
- abort  input  1  terminate run early; jump to flush.
- fill_time  input  CNT_W  FILL phase duration, cycles.
- mix_time  input  CNT_W  MIX phase duration per level, cycles.
- xfer_time  input  CNT_W  XFER phase duration per level, cycles.
- flush_time  input  CNT_W  FLUSH phase duration, cycles.
- inlet_valve  output  2**LEVELS  leaf inlet valves; all open in FILL.
- mix_pump  output  LEVELS  peristaltic pump of level l; bit l high in MIX(l).
- stage_valve  output  LEVELS  transfer valve out of level l; bit l high in XFER(l).
- out_valve  output  1  tree outlet valve; high in FLUSH.
- busy  output  1  high in FILL, MIX, XFER, FLUSH.
- done  output  1  one-cycle pulse at end of run.
- aborted  output  1  last run ended by abort.
- level  output  $clog2(LEVELS+1)  current level index; 0 outside MIX/XFER.
- run_count  output  RUN_W  number of runs completed without abort.

## Operation
- States: IDLE, FILL, MIX, XFER, FLUSH, DONE.
- IDLE: start=1 latches all four durations, clears aborted, sets level=0 → FILL.
- Durations of 0 are clamped to 1 at latch time; inputs changed mid-run have no effect.
- FILL: inlet_valve all ones for fill_time cycles → MIX(level 0).
- MIX(l): mix_pump[l]=1 for mix_time cycles → XFER(l).
- XFER(l): stage_valve[l]=1 for xfer_time cycles; if l<LEVELS-1 → MIX(l+1), else → FLUSH.
- FLUSH: out_valve=1 for flush_time cycles → DONE.
- DONE: done=1 for one cycle, busy=0; run_count += 1 unless aborted; → IDLE.
- run_count wraps modulo 2**RUN_W.
- abort=1 in FILL, MIX or XFER: next cycle enters FLUSH with full latched flush_time, aborted=1, all other valves/pumps closed.
- abort in IDLE, FLUSH, DONE: ignored. start outside IDLE: ignored.
- start and abort both high in IDLE: start wins; abort ignored that cycle.
- At most one valve group or pump is active in any cycle (never two phases overlap).

## Timing
- All outputs registered, decoded from the registered state; no combinational input→output path.
- Reset values: state IDLE, inlet_valve=0, mix_pump=0, stage_valve=0, out_valve=0, busy=0, done=0, aborted=0, level=0, run_count=0.
- Reset asserted mid-run: all valves/pumps closed on the next cycle; run not counted.
- start sampled at edge k: FILL outputs active cycles k+1 .. k+F.
- done high in cycle k + F + LEVELS·(M+X) + U + 1 (F,M,X,U = clamped durations); IDLE from the following cycle, new start accepted there.
- abort sampled at edge j during FILL/MIX/XFER: out_valve high cycles j+1 .. j+U; done in cycle j+U+1.

## Test plan
- LEVELS=3, F=4, M=5, X=2, U=3, start at k → inlet_valve=8'hFF cycles k+1..k+4; mix_pump[2] cycles k+19..k+23; done only in cycle k+29; run_count=1, aborted=0.
- All durations 0 → each phase lasts 1 cycle; done in cycle k+1+3·2+1+1 = k+9.
- abort during MIX(1) at edge j, U=3 → mix_pump=0 from j+1, out_valve j+1..j+3, done at j+4, aborted=1, run_count unchanged.
- start pulsed while busy and abort in IDLE → no state change; timing identical to undisturbed run.
- rst asserted in XFER(0) → all outputs 0 next cycle, run_count=0; fresh start then runs normally.
- RUN_W=2, four back-to-back runs → run_count sequence 1,2,3,0; each exclusivity check (one active group per cycle) holds throughout.
